// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end.
//   fetch_state_e : instruction fetch FSM states
//   NOP_INSTR     : canonical bubble, ADDI x0,x0,0
//   PC_STEP       : sequential PC increment in bytes
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register between fetch and decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds misalign flag).
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture load_instr/load_pc (and load_misalign), set valid
//   flush           : drop the held entry (has priority over load)
//   ready           : downstream accepts the held entry
//   valid/instr/pc  : entry presented downstream; instr is NOP while invalid
module fetch_out_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic        load_misalign,
    output logic        misalign,
`endif
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= RESET_PC;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (flush) begin
            misalign <= 1'b0;
        end else if (load) begin
            misalign <= load_misalign;
        end else if (valid && ready) begin
            misalign <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: owns the PC, issues single-outstanding word
// fetches over req/gnt/rvalid, and hands instructions to decode via
// valid/ready. Redirects from execute flush any in-flight fetch.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap,
// adds output if_misalign).
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req/imem_addr       : fetch request and byte address (= pc_q)
//   imem_gnt                 : request accepted
//   imem_rvalid/imem_rdata   : instruction response
//   redirect_valid/_pc       : control-flow redirect
//   if_valid/if_ready        : handshake to decode
//   if_instr/if_pc           : fetched word and its PC
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        if_misalign,
`endif
    output logic [31:0] if_pc
);
    import rv32i_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_pc;
    logic         slot_free;
    logic         resp_load;
    logic         trap_load;
    logic         fetch_halt;
    logic         out_load;
    logic         out_flush;

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned target is taken as-is; fetching stops until the next
    // redirect and a single trap marker is handed to decode instead.
    assign target_pc = redirect_pc;
    assign trap_load = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_halt <= 1'b0;
        end else if (redirect_valid) begin
            fetch_halt <= trap_load;
        end
    end
`else
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign trap_load  = 1'b0;
    assign fetch_halt = 1'b0;
`endif

    // The slot is free if empty or being drained this cycle, so a new fetch
    // can never overwrite an entry decode has not taken.
    assign slot_free = !if_valid || if_ready;
    assign imem_req  = (state_q == REQ) && slot_free && !fetch_halt;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_load = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A grant in the redirect cycle still leaves a response in
                // flight, which DISCARD must swallow.
                if (imem_req && imem_gnt) begin
                    state_d = redirect_valid ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    if (!redirect_valid) begin
                        resp_load = 1'b1;
                        pc_d      = pc_q + PC_STEP;
                    end
                end else if (redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = target_pc;
        end
    end

    // Trap marker and response load are mutually exclusive: a response is
    // only loaded when no redirect is present.
    assign out_load  = resp_load || trap_load;
    assign out_flush = redirect_valid && !trap_load;

    fetch_out_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (out_load),
        .flush         (out_flush),
        .ready         (if_ready),
        .load_instr    (trap_load ? NOP_INSTR : imem_rdata),
        .load_pc       (trap_load ? redirect_pc : pc_q),
`ifdef FETCH_MISALIGN_TRAP_EN
        .load_misalign (trap_load),
        .misalign      (if_misalign),
`endif
        .valid         (if_valid),
        .instr         (if_instr),
        .pc            (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          RV_LAT = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misalign    (if_misalign),
`endif
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    bit          outst = 0;
    bit          stale = 0;
    bit          gnt_seen = 0;
    int          wcnt = 0;
    logic [31:0] gaddr = 32'h0;
    logic [31:0] mpc = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return a ^ 32'h1234_5678;
        endcase
    endfunction

    // One clock of memory model + scoreboard. Entered and left at posedge+1.
    task automatic tick();
        bit   resp;
        exp_t e;
        @(negedge clk);
        resp        = 1'b0;
        imem_rvalid = 1'b0;
        if (outst) begin
            if (wcnt == 0) begin
                resp        = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = stale ? 32'hDEADBEEF : mem_word(gaddr);
            end else begin
                wcnt = wcnt - 1;
            end
        end
        #1;
        imem_gnt = imem_req;
        gnt_seen = imem_gnt;
        if (outst) chk("req_while_outstanding", {31'b0, imem_req}, 32'd0);
        if (if_valid && if_ready) begin
            chk("scoreboard_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.instr);
            end
            pops++;
        end
        if (imem_gnt) chk("fetch_addr", imem_addr, mpc);
        if (resp && !stale && !redirect_valid) begin
            sb.push_back('{gaddr, imem_rdata});
            mpc = gaddr + 32'd4;
        end
        if (redirect_valid) sb.delete();
        @(posedge clk);
        #1;
        if (resp) begin
            outst = 0;
            stale = 0;
        end
        if (imem_gnt) begin
            outst = 1;
            wcnt  = RV_LAT - 1;
            gaddr = mpc;
            stale = redirect_valid;
        end else if (redirect_valid && outst) begin
            stale = 1;
        end
        if (redirect_valid) mpc = redirect_pc;
    endtask

    task automatic wait_grant();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = gnt_seen;
        end
        chk("grant_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !if_valid; i++) tick();
        chk("valid_timeout", {31'b0, if_valid}, 32'd1);
    endtask

    task automatic run_pops(input int n);
        int target = pops + n;
        for (int i = 0; i < 60 && pops < target; i++) tick();
        chk("pop_timeout", {31'b0, pops >= target}, 32'd1);
    endtask

    task automatic redirect_tick(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First instruction held by decode for 5 cycles, then stream resumes.
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h0);
            chk("stall_instr", if_instr, 32'h0050_0093);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        run_pops(2);

        // Redirect during WAIT: stale word must be dropped.
        wait_grant();
        redirect_tick(32'h0000_0100);
        chk("redir_wait_valid", {31'b0, if_valid}, 32'd0);
        chk("redir_wait_instr", if_instr, NOP);
        run_pops(1);

        // Redirect coinciding with rvalid: straight back to REQ.
        wait_grant();
        tick();
        redirect_tick(32'h0000_0200);
        chk("redir_rvalid_req", {31'b0, imem_req}, 32'd1);
        chk("redir_rvalid_addr", imem_addr, 32'h0000_0200);
        run_pops(1);

        // PC wrap at the top of the address space.
        wait_grant();
        redirect_tick(32'hFFFF_FFFC);
        run_pops(2);

        // Asynchronous reset in the middle of WAIT.
        wait_grant();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, NOP);
        sb.delete();
        outst       = 0;
        stale       = 0;
        mpc         = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_pops(1);

`ifdef FETCH_MISALIGN_TRAP_EN
        if_ready = 1'b0;
        redirect_tick(32'h0000_0102);
        chk("mis_valid", {31'b0, if_valid}, 32'd1);
        chk("mis_flag", {31'b0, if_misalign}, 32'd1);
        chk("mis_pc", if_pc, 32'h0000_0102);
        chk("mis_instr", if_instr, NOP);
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mis_no_req", {31'b0, imem_req}, 32'd0);
        end
        sb.delete();
`endif

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
